// File: rtl/func_bindec_sched_pkg.sv
// Shared defaults, state encoding, converter exception codes and issue payload.
package func_bindec_sched_pkg;

    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_LATENCY = 17;
    localparam int unsigned DEF_SLOTS   = 16;
    localparam int unsigned DATA_W      = 64;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_FLUSHED = 2'd2
    } state_e;

    // Binary-to-decimal converter exception flags
    localparam logic [4:0] EXC_NONE      = 5'b00000;
    localparam logic [4:0] EXC_INEXACT   = 5'b00001;
    localparam logic [4:0] EXC_UNDERFLOW = 5'b00010;
    localparam logic [4:0] EXC_OVERFLOW  = 5'b00100;
    localparam logic [4:0] EXC_DIVZERO   = 5'b01000;
    localparam logic [4:0] EXC_INVALID   = 5'b10000;

    // Operand bundle forwarded to the converter on issue
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        size;
        logic [1:0]        rmode;
        logic              away;
    } conv_op_t;

endpackage

// File: rtl/func_bindec_sched_arb.sv
// Round-robin arbiter: search starts one past the last winner.
module bindec_rr_arb #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_c
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] win_c;
    logic          found_c;

    // Priority search rotated by the pointer
    always_comb begin
        gnt_c   = '0;
        win_c   = '0;
        found_c = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found_c && req_i[PW'((32'(ptr_q) + k) % NREQ)]) begin
                found_c = 1'b1;
                win_c   = PW'((32'(ptr_q) + k) % NREQ);
                gnt_c[PW'((32'(ptr_q) + k) % NREQ)] = 1'b1;
            end
        end
    end

    // Pointer moves past the winner only when the grant is taken
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (adv_i && found_c) begin
            ptr_q <= (win_c == PW'(NREQ - 1)) ? '0 : win_c + 1'b1;
        end
    end

endmodule

// File: rtl/func_bindec_sched.sv
// Issue scheduler for a shared binary-to-decimal converter with a slot-based result buffer.
module func_bindec_sched
    import func_bindec_sched_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned SLOTS   = DEF_SLOTS
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*64-1:0]     req_data,
    input  logic [NREQ*2-1:0]      req_size,
    input  logic [NREQ*2-1:0]      req_rmode,
    input  logic [NREQ-1:0]        req_away,
    output logic [NREQ-1:0]        gnt,
    output logic [$clog2(SLOTS)-1:0] gnt_slot,
    output logic                   conv_wren,
    output logic [$clog2(SLOTS)-1:0] conv_wraddrs,
    output logic [63:0]            conv_wrdata,
    output logic [1:0]             conv_size,
    output logic [1:0]             conv_rmode,
    output logic                   conv_away,
    output logic                   done_vld,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id,
    output logic [$clog2(SLOTS)-1:0] done_slot,
    input  logic                   rel_vld,
    input  logic [$clog2(SLOTS)-1:0] rel_slot,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [$clog2(SLOTS):0] inflight
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = $clog2(SLOTS);
    localparam int unsigned CW = SW + 1;
    // Last delay stage is the done output register itself
    localparam int unsigned PD = LATENCY - 1;

    state_e            state_q;
    logic [SLOTS-1:0]  busy_q;
    logic [SLOTS-1:0]  cmpl_q;
    logic [IW-1:0]     owner_q [SLOTS];
    logic [PD-1:0]     pv_q;
    logic [SW-1:0]     ps_q [PD];

    logic [NREQ-1:0]   arb_gnt_c;
    logic              issue_c;
    logic              slot_avail_c;
    logic [SW-1:0]     alloc_slot_c;
    logic [IW-1:0]     gidx_c;
    conv_op_t          sel_op_c;
    logic              rel_ok_c;
    logic              pipe_busy_c;

    bindec_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .req_i  (req),
        .adv_i  (issue_c),
        .gnt_c  (arb_gnt_c)
    );

    // Lowest-index free slot
    always_comb begin
        slot_avail_c = 1'b0;
        alloc_slot_c = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                slot_avail_c = 1'b1;
                alloc_slot_c = SW'(i);
            end
        end
    end

    // Operand mux driven by the one-hot arbiter grant
    always_comb begin
        gidx_c   = '0;
        sel_op_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt_c[i]) begin
                gidx_c         = IW'(i);
                sel_op_c.data  = req_data[i*64 +: 64];
                sel_op_c.size  = req_size[i*2 +: 2];
                sel_op_c.rmode = req_rmode[i*2 +: 2];
                sel_op_c.away  = req_away[i];
            end
        end
    end

    // Issue, release and drain qualifiers
    always_comb begin
        issue_c     = (state_q == ST_RUN) && !flush && slot_avail_c && (|req);
        rel_ok_c    = rel_vld && busy_q[rel_slot] && cmpl_q[rel_slot];
        pipe_busy_c = conv_wren || (|pv_q);
    end

    // Registered issue port; data fields hold while idle
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            gnt          <= '0;
            gnt_slot     <= '0;
            conv_wren    <= 1'b0;
            conv_wraddrs <= '0;
            conv_wrdata  <= '0;
            conv_size    <= '0;
            conv_rmode   <= '0;
            conv_away    <= 1'b0;
        end else begin
            conv_wren <= issue_c;
            gnt       <= issue_c ? arb_gnt_c : '0;
            if (issue_c) begin
                gnt_slot     <= alloc_slot_c;
                conv_wraddrs <= alloc_slot_c;
                conv_wrdata  <= sel_op_c.data;
                conv_size    <= sel_op_c.size;
                conv_rmode   <= sel_op_c.rmode;
                conv_away    <= sel_op_c.away;
            end
        end
    end

    // Write-back delay line of {valid, slot}; owner looked up on exit
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pv_q      <= '0;
            done_vld  <= 1'b0;
            done_slot <= '0;
            done_id   <= '0;
            for (int i = 0; i < int'(PD); i++) begin
                ps_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= conv_wren;
            ps_q[0] <= conv_wraddrs;
            for (int i = 1; i < int'(PD); i++) begin
                pv_q[i] <= pv_q[i-1];
                ps_q[i] <= ps_q[i-1];
            end
            done_vld  <= pv_q[PD-1];
            done_slot <= ps_q[PD-1];
            done_id   <= owner_q[ps_q[PD-1]];
        end
    end

    // Slot table: allocation, completion marking, release
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            busy_q   <= '0;
            cmpl_q   <= '0;
            inflight <= '0;
            for (int i = 0; i < int'(SLOTS); i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            if (issue_c) begin
                busy_q[alloc_slot_c]  <= 1'b1;
                cmpl_q[alloc_slot_c]  <= 1'b0;
                owner_q[alloc_slot_c] <= gidx_c;
            end
            if (pv_q[PD-1]) begin
                cmpl_q[ps_q[PD-1]] <= 1'b1;
            end
            if (rel_ok_c) begin
                busy_q[rel_slot] <= 1'b0;
                cmpl_q[rel_slot] <= 1'b0;
            end
            inflight <= inflight + CW'(issue_c) - CW'(rel_ok_c);
        end
    end

    // Run / drain / flushed control
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_RUN;
            flush_done <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!pipe_busy_c) begin
                        state_q    <= ST_FLUSHED;
                        flush_done <= 1'b1;
                    end
                end
                ST_FLUSHED: begin
                    if (!flush) begin
                        state_q    <= ST_RUN;
                        flush_done <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
